// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Instruction word layout: opcode in bits [15:12]; an all-zero word is a bubble (NOP).
package fetch_stage_pkg;

  localparam int ADDR_W = 8;
  localparam int INST_W = 16;

  localparam int OP_BEGIN = 15;
  localparam int OP_END   = 12;

  localparam logic [OP_BEGIN-OP_END:0] OP_HALT = 4'b1111;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [INST_W-1:0] block_t;

  typedef struct packed {
    block_t inst;
    addr_t  pc;
  } inst_t;

  localparam block_t NOP_INST = '0;
  localparam inst_t  BUBBLE   = '{inst: NOP_INST, pc: '0};

  typedef enum logic [1:0] {
    RUN,
    HOLD,
    HALT
  } fetch_state_t;

  function automatic logic is_halt(block_t b);
    return b[OP_BEGIN:OP_END] == OP_HALT;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction ROM bus: the request strobe and address go out, read data comes back one cycle later.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic   imem_req;
  addr_t  imem_addr;
  block_t imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_rdata);

endinterface

// File: rtl/fetch_stage_skid.sv
// One-entry skid buffer that holds a ROM response which arrives while decode is stalled.
// Flush takes priority over push.
module fetch_skid
  import fetch_stage_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  logic  pop,
  input  logic  flush,
  input  inst_t din,
  output inst_t dout,
  output logic  valid
);

  // NOTE: sequential state is assigned with non-blocking (<=) so every flop samples pre-edge values.
  // NOTE: the payload is reset as well as the valid bit; it is a single register, and a known value keeps dout clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      dout  <= BUBBLE;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (push) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads a 1-cycle-latency ROM, applies redirects, handles stalls and halts.
// Optional performance counters are compiled in when FETCH_PERF_CNT_EN is defined.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter addr_t RESET_PC = 8'h00
)
(
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                do_branch,
  input  addr_t               branch_target,
  input  logic                do_jump,
  input  addr_t               jump_address,
  fetch_stage_if.master       imem,
  output inst_t               fetch_inst,
  output logic                fetch_halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]         perf_fetched,
  output logic [31:0]         perf_bubbles
`endif
);

  fetch_state_t state;
  addr_t        pc;
  addr_t        req_pc;
  logic         pending;

  logic  redirect;
  addr_t target;
  inst_t rsp;
  inst_t load_inst;
  logic  skid_push;
  logic  skid_pop;
  logic  skid_valid;
  inst_t skid_dout;

  // NOTE: every signal written here gets a value on every path, so no latch is inferred.
  always_comb begin
    redirect        = do_branch | do_jump;
    target          = do_branch ? branch_target : jump_address;
    imem.imem_req   = !rst && (redirect || (state != HALT && !stall));
    imem.imem_addr  = redirect ? target : pc;
    rsp             = '{inst: imem.imem_rdata, pc: req_pc};
    skid_push       = !redirect && stall && pending && state != HALT;
    skid_pop        = !redirect && !stall && state == HOLD && skid_valid;
    if (skid_pop)     load_inst = skid_dout;
    else if (pending) load_inst = rsp;
    else              load_inst = BUBBLE;
  end

  fetch_skid u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (skid_push),
    .pop   (skid_pop),
    .flush (redirect),
    .din   (rsp),
    .dout  (skid_dout),
    .valid (skid_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      pc         <= RESET_PC;
      req_pc     <= RESET_PC;
      pending    <= 1'b0;
      fetch_inst <= BUBBLE;
    end else if (redirect) begin
      // The request for the target goes out this cycle; whatever was in flight is dropped.
      state      <= RUN;
      pc         <= target + addr_t'(1);
      req_pc     <= target;
      pending    <= 1'b1;
      fetch_inst <= BUBBLE;
    end else begin
      case (state)
        RUN, HOLD: begin
          if (stall) begin
            state   <= HOLD;
            pending <= 1'b0;
          end else begin
            fetch_inst <= load_inst;
            if (is_halt(load_inst.inst)) begin
              // Park the PC just past the halt and drop the request issued behind it.
              state   <= HALT;
              pc      <= load_inst.pc + addr_t'(1);
              pending <= 1'b0;
            end else begin
              state   <= RUN;
              pc      <= pc + addr_t'(1);
              req_pc  <= pc;
              pending <= 1'b1;
            end
          end
        end
        HALT: begin
          if (!stall) fetch_inst <= BUBBLE;
        end
        default: state <= RUN;
      endcase
    end
  end

  assign fetch_halted = (state == HALT);

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (fetch_inst.inst != NOP_INST && !stall && perf_fetched != '1)
        perf_fetched <= perf_fetched + 32'd1;
      if (fetch_inst.inst == NOP_INST && perf_bubbles != '1)
        perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes the program-order instruction stream, a monitor checks decode-side acceptances.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  stall = 1'b0;
  logic  do_branch = 1'b0;
  logic  do_jump = 1'b0;
  addr_t branch_target = '0;
  addr_t jump_address = '0;
  inst_t fetch_inst;
  logic  fetch_halted;

  fetch_stage_if imem ();

  fetch_stage #(.RESET_PC(8'h00)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .do_branch     (do_branch),
    .branch_target (branch_target),
    .do_jump       (do_jump),
    .jump_address  (jump_address),
    .imem          (imem),
    .fetch_inst    (fetch_inst),
    .fetch_halted  (fetch_halted)
  );

  always #5 clk = ~clk;

  block_t rom [256];

  always @(posedge clk)
    if (imem.imem_req) imem.imem_rdata <= rom[imem.imem_addr];

  typedef struct {
    logic  marker;
    inst_t item;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic halt_word(block_t w);
    return w[15:12] == 4'hF;
  endfunction

  // Program order from t: every non-zero word in ascending (wrapping) address order, ending at a halt.
  function automatic void push_stream(addr_t t);
    exp_t  e;
    inst_t it;
    addr_t a;
    a = t;
    e.marker = 1'b1;
    e.item = '0;
    exp_q.push_back(e);
    for (int n = 0; n < 200; n++) begin
      if (rom[a] != '0) begin
        it.inst = rom[a];
        it.pc = a;
        e.marker = 1'b0;
        e.item = it;
        exp_q.push_back(e);
      end
      if (halt_word(rom[a])) break;
      a = a + addr_t'(1);
    end
  endfunction

  function automatic logic halt_within(addr_t t, int n);
    for (int i = 0; i < n; i++)
      if (halt_word(rom[t + addr_t'(i)])) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void flush_to_marker();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.marker) break;
    end
  endfunction

  int    age = -1;
  logic  clean = 1'b0;
  addr_t tgt = '0;
  logic  halt_seen = 1'b0;
  logic  prev_rst = 1'b0;
  int    idle = 0;

  always @(negedge clk) begin : monitor
    exp_t  e;
    logic  redirect;
    addr_t exp_addr;
    addr_t exp_pc;
    redirect = do_branch || do_jump;
    if (rst) begin
      if (!prev_rst) flush_to_marker();
      check("reset_fetch_inst", 32'(fetch_inst), 32'(0));
      check("reset_imem_req", 32'(imem.imem_req), 32'(0));
      check("reset_halted", 32'(fetch_halted), 32'(0));
      age = -1;
      clean = 1'b1;
      tgt = 8'h00;
      halt_seen = 1'b0;
      idle = 0;
    end else begin
      if (age < 1000) age++;
      if (age == 1) begin
        check("restart_bubble", 32'(fetch_inst.inst), 32'(0));
        check("restart_not_halted", 32'(fetch_halted), 32'(0));
      end
      if (age >= 2 && age <= 5 && clean && !halt_within(tgt, age - 2)) begin
        exp_pc = tgt + addr_t'(age - 2);
        check("stream_timing", 32'(fetch_inst), {8'h00, rom[exp_pc], exp_pc});
      end
      if (fetch_inst.inst != '0 && !stall) begin
        idle = 0;
        if (exp_q.size() == 0 || exp_q[0].marker) begin
          checks++;
          errors++;
          $display("FAIL unexpected_inst: got %h want none at %0t", fetch_inst, $time);
        end else begin
          e = exp_q.pop_front();
          check("accepted_inst", 32'(fetch_inst), 32'(e.item));
          if (halt_word(e.item.inst)) halt_seen = 1'b1;
        end
      end else if (!halt_seen) begin
        idle++;
        if (idle > 200) begin
          checks++;
          errors++;
          $display("FAIL no_progress: got %0d idle cycles want <= 200 at %0t", idle, $time);
          idle = 0;
        end
      end
      if (!redirect) begin
        if (halt_seen) begin
          check("halt_no_req", 32'(imem.imem_req), 32'(0));
          check("halt_flag", 32'(fetch_halted), 32'(1));
        end else if (stall) begin
          check("stall_no_req", 32'(imem.imem_req), 32'(0));
        end else begin
          check("run_req", 32'(imem.imem_req), 32'(1));
        end
      end
      clean = clean && !stall;
      if (redirect) begin
        exp_addr = do_branch ? branch_target : jump_address;
        check("redirect_req", 32'(imem.imem_req), 32'(1));
        check("redirect_addr", 32'(imem.imem_addr), 32'(exp_addr));
        flush_to_marker();
        tgt = exp_addr;
        age = 0;
        clean = 1'b1;
        halt_seen = 1'b0;
        idle = 0;
      end
    end
    prev_rst = rst;
  end

  task automatic step(logic s, logic b, addr_t bt, logic j, addr_t ja);
    @(posedge clk);
    #1;
    stall = s;
    do_branch = b;
    branch_target = bt;
    do_jump = j;
    jump_address = ja;
    if (b) push_stream(bt);
    else if (j) push_stream(ja);
  endtask

  task automatic idle_steps(int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic pulse_reset(int cycles);
    @(posedge clk);
    #1;
    do_branch = 1'b0;
    do_jump = 1'b0;
    push_stream(8'h00);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    stall = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int    since;
    int    kind;
    logic  s;
    addr_t t1;
    addr_t t2;
    for (int i = 0; i < 256; i++) rom[i] = block_t'($urandom_range(0, 65535));
    rom[0] = 16'h1234; rom[1] = 16'h5678; rom[2] = 16'h9ABC; rom[3] = 16'h0000;
    rom[4] = 16'h1111; rom[5] = 16'h2222; rom[6] = 16'h3333; rom[7] = 16'hF000;
    rom[8'hFD] = 16'h4444; rom[8'hFE] = 16'h5555; rom[8'hFF] = 16'h6666;
    for (int i = 8'h10; i < 8'h18; i++) rom[i] = 16'h0100 + block_t'(i);
    for (int i = 8'h40; i < 8'h48; i++) rom[i] = 16'h0200 + block_t'(i);

    push_stream(8'h00);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset stream, then jump at cycle 5
    idle_steps(4);
    step(1'b0, 1'b0, '0, 1'b1, 8'h40);
    idle_steps(7);
    // branch and jump together: branch wins
    step(1'b0, 1'b1, 8'h10, 1'b1, 8'h20);
    idle_steps(4);
    // three-cycle stall with a request in flight
    step(1'b1, 1'b0, '0, 1'b0, '0);
    step(1'b1, 1'b0, '0, 1'b0, '0);
    step(1'b1, 1'b0, '0, 1'b0, '0);
    idle_steps(6);
    // run into the halt at 7, sit halted, then branch back to 2
    step(1'b0, 1'b0, '0, 1'b1, 8'h04);
    idle_steps(25);
    step(1'b0, 1'b1, 8'h02, 1'b0, '0);
    idle_steps(10);
    // PC wrap, then reset in the middle of a stall
    step(1'b0, 1'b0, '0, 1'b1, 8'hFD);
    idle_steps(6);
    step(1'b1, 1'b0, '0, 1'b0, '0);
    step(1'b1, 1'b0, '0, 1'b0, '0);
    pulse_reset(2);
    idle_steps(6);

    since = 0;
    for (int c = 0; c < 2500; c++) begin
      s = ($urandom_range(0, 9) < 3);
      since++;
      if (since > 60 || $urandom_range(0, 29) == 0) begin
        kind = int'($urandom_range(0, 2));
        t1 = addr_t'($urandom_range(0, 255));
        t2 = addr_t'($urandom_range(0, 255));
        if ($urandom_range(0, 7) == 0) t1 = 8'hFC;
        step(s, kind != 1, t1, kind != 0, t2);
        since = 0;
      end else if ($urandom_range(0, 799) == 0) begin
        if (s) step(1'b1, 1'b0, '0, 1'b0, '0);
        pulse_reset(int'($urandom_range(1, 3)));
        since = 0;
      end else begin
        step(s, 1'b0, '0, 1'b0, '0);
      end
    end
    idle_steps(10);
    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
